// File: rtl/ps2_pkg.sv
// Shared types for the PS/2 scan-code receiver: frame states, prefix bytes, FIFO entry layout.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_t;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_entry_t;

endpackage

// File: rtl/ps2_sync_filter.sv
// Two-flop synchronizer plus glitch filter for one PS/2 line; output idles high.
// Latency: 2 sync cycles + FILT_LEN filter cycles; no backpressure.
module ps2_sync_filter #(
  parameter int FILT_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  localparam int CW = $clog2(FILT_LEN) + 1;

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;

  // cnt counts consecutive synchronized samples that disagree with dout
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1   <= 1'b1;
      s2   <= 1'b1;
      cnt  <= '0;
      dout <= 1'b1;
    end else begin
      s1 <= din;
      s2 <= s1;
      if (s2 == dout) begin
        cnt <= '0;
      end else if (cnt == CW'(FILT_LEN - 1)) begin
        dout <= s2;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_scan_rx.sv
// PS/2 keyboard receiver: frames bytes, folds E0/F0 prefixes into flags, buffers events in a FIFO.
// Latency: filter + 2 cycles after the stop-bit edge; full FIFO drops entries (sticky overflow).
// Optional PS2_TYPEMATIC_FILTER_EN drops repeated makes of the same key.
module ps2_scan_rx
  import ps2_pkg::*;
#(
  parameter int FILT_LEN    = 4,
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clk_pc2,
  input  logic                          data_pc2,
  input  logic                          rd_en,
  output logic                          out_valid,
  output logic [7:0]                    out_code,
  output logic                          out_break,
  output logic                          out_ext,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          overflow,
  output logic                          frame_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYC - 1);

  logic clk_f, dat_f, clk_prev, sample;

  ps2_sync_filter #(.FILT_LEN(FILT_LEN)) u_clk_filt (.clk(clk), .rst(rst), .din(clk_pc2),  .dout(clk_f));
  ps2_sync_filter #(.FILT_LEN(FILT_LEN)) u_dat_filt (.clk(clk), .rst(rst), .din(data_pc2), .dout(dat_f));

  // sample is the registered falling-edge strobe, one cycle after detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_prev <= 1'b1;
      sample   <= 1'b0;
    end else begin
      clk_prev <= clk_f;
      sample   <= clk_prev & ~clk_f;
    end
  end

  ps2_state_t    state;
  logic [2:0]    bit_cnt;
  logic [TW-1:0] to_cnt;
  logic [7:0]    shift;
  logic          par;
  logic          ext_pend, brk_pend;
  logic          push_vld;
  ps2_entry_t    push_ent;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      to_cnt    <= '0;
      shift     <= '0;
      par       <= 1'b0;
      ext_pend  <= 1'b0;
      brk_pend  <= 1'b0;
      frame_err <= 1'b0;
      push_vld  <= 1'b0;
      push_ent  <= '0;
    end else begin
      frame_err <= 1'b0;
      push_vld  <= 1'b0;
      if (state == IDLE || sample) to_cnt <= '0;
      else                         to_cnt <= to_cnt + 1'b1;

      if (state != IDLE && !sample && to_cnt == TO_LAST) begin
        state     <= IDLE;
        bit_cnt   <= '0;
        shift     <= '0;
        frame_err <= 1'b1;
        ext_pend  <= 1'b0;
        brk_pend  <= 1'b0;
      end else if (sample) begin
        case (state)
          IDLE: begin
            if (!dat_f) begin
              state   <= DATA;
              bit_cnt <= '0;
            end else begin
              frame_err <= 1'b1;
              ext_pend  <= 1'b0;
              brk_pend  <= 1'b0;
            end
          end
          DATA: begin
            shift   <= {dat_f, shift[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par   <= dat_f;
            state <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (dat_f && (^{shift, par})) begin
              if (shift == PS2_EXT) begin
                ext_pend <= 1'b1;
              end else if (shift == PS2_BRK) begin
                brk_pend <= 1'b1;
              end else begin
                push_vld      <= 1'b1;
                push_ent.ext  <= ext_pend;
                push_ent.brk  <= brk_pend;
                push_ent.code <= shift;
                ext_pend      <= 1'b0;
                brk_pend      <= 1'b0;
              end
            end else begin
              frame_err <= 1'b1;
              ext_pend  <= 1'b0;
              brk_pend  <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  logic wr;

`ifdef PS2_TYPEMATIC_FILTER_EN
  logic       mem_vld;
  logic [8:0] mem_make;
  logic       dup;

  assign dup = mem_vld && !push_ent.brk && (mem_make == {push_ent.ext, push_ent.code});
  assign wr  = push_vld && !dup;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_vld  <= 1'b0;
      mem_make <= '0;
    end else if (push_vld) begin
      if (push_ent.brk) begin
        mem_vld <= 1'b0;
      end else begin
        mem_vld  <= 1'b1;
        mem_make <= {push_ent.ext, push_ent.code};
      end
    end
  end
`else
  assign wr = push_vld;
`endif

  ps2_entry_t    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;
  ps2_entry_t    head;

  assign out_valid = (count != '0);
  assign do_pop    = rd_en && out_valid;
  // a pop in the same cycle frees the slot, so a full FIFO still accepts
  assign do_push   = wr && ((count != FULL_CNT) || do_pop);
  assign head      = fifo_mem[rd_ptr];
  assign out_code  = out_valid ? head.code : 8'h00;
  assign out_break = out_valid & head.brk;
  assign out_ext   = out_valid & head.ext;

  always_ff @(posedge clk) begin
    if (do_push) fifo_mem[wr_ptr] <= push_ent;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (wr && !do_push) overflow <= 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_scan_rx.sv
// Directed bench for ps2_scan_rx with a queue of expected FIFO entries.
module tb_ps2_scan_rx;

  localparam int FILT_LEN    = 4;
  localparam int FIFO_DEPTH  = 8;
  localparam int TIMEOUT_CYC = 300;
  localparam int HALF        = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clk_pc2 = 1'b1;
  logic       data_pc2 = 1'b1;
  logic       rd_en = 1'b0;
  logic       out_valid;
  logic [7:0] out_code;
  logic       out_break;
  logic       out_ext;
  logic [3:0] count;
  logic       overflow;
  logic       frame_err;

  int pass_cnt = 0;
  int tot_cnt  = 0;
  int err_cnt  = 0;
  int err_base;
  logic [9:0] exp_q[$];

  ps2_scan_rx #(
    .FILT_LEN(FILT_LEN), .FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .rst(rst), .clk_pc2(clk_pc2), .data_pc2(data_pc2), .rd_en(rd_en),
    .out_valid(out_valid), .out_code(out_code), .out_break(out_break), .out_ext(out_ext),
    .count(count), .overflow(overflow), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (frame_err) err_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tot_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ps2_bit(input logic v);
    data_pc2 = v;
    wait_cyc(HALF);
    clk_pc2 = 1'b0;
    wait_cyc(HALF);
    clk_pc2 = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits);
    logic [10:0] fr;
    fr = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) ps2_bit(fr[i]);
    data_pc2 = 1'b1;
    wait_cyc(2 * HALF);
  endtask

  task automatic send_ok(input logic [7:0] b);
    send_frame(b, 1'b0, 11);
  endtask

  task automatic pop_check(input string tag);
    logic [9:0] e;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 10'h3FF;
    chk({tag, " valid"}, 32'(out_valid), 32'd1);
    chk({tag, " code"},  32'(out_code),  32'(e[7:0]));
    chk({tag, " break"}, 32'(out_break), 32'(e[8]));
    chk({tag, " ext"},   32'(out_ext),   32'(e[9]));
    rd_en = 1'b1;
    wait_cyc(1);
    rd_en = 1'b0;
    wait_cyc(1);
  endtask

  initial begin
    wait_cyc(3);
    rst = 1'b0;
    wait_cyc(2);
    chk("rst valid", 32'(out_valid), 32'd0);
    chk("rst count", 32'(count), 32'd0);
    chk("rst overflow", 32'(overflow), 32'd0);
    chk("rst code", 32'(out_code), 32'd0);
    chk("rst brkext", 32'({out_break, out_ext}), 32'd0);

    // single make code
    send_ok(8'h1C);
    exp_q.push_back({2'b00, 8'h1C});
    chk("make count", 32'(count), 32'd1);
    pop_check("make");
    chk("make empty", 32'(out_valid), 32'd0);
    chk("make empty code", 32'(out_code), 32'd0);

    // extended break
    send_ok(8'hE0);
    send_ok(8'hF0);
    send_ok(8'h75);
    exp_q.push_back({2'b11, 8'h75});
    chk("extbrk count", 32'(count), 32'd1);
    pop_check("extbrk");

    // parity error clears a pending E0
    err_base = err_cnt;
    send_ok(8'hE0);
    send_frame(8'h1C, 1'b1, 11);
    chk("parity err", 32'(err_cnt - err_base), 32'd1);
    chk("parity no entry", 32'(count), 32'd0);
    send_ok(8'hF0);
    send_ok(8'h1C);
    exp_q.push_back({2'b01, 8'h1C});
    pop_check("after parity");

    // bad start bit
    err_base = err_cnt;
    ps2_bit(1'b1);
    wait_cyc(2 * HALF);
    chk("bad start err", 32'(err_cnt - err_base), 32'd1);
    chk("bad start count", 32'(count), 32'd0);

    // timeout mid-frame
    err_base = err_cnt;
    send_frame(8'h55, 1'b0, 9);
    wait_cyc(TIMEOUT_CYC + 10);
    chk("timeout err", 32'(err_cnt - err_base), 32'd1);
    chk("timeout count", 32'(count), 32'd0);
    send_ok(8'h2A);
    exp_q.push_back({2'b00, 8'h2A});
    pop_check("after timeout");

    // overflow: one frame more than the FIFO holds
    for (int i = 0; i <= FIFO_DEPTH; i++) begin
      send_ok(8'h10 + 8'(i));
      if (i < FIFO_DEPTH) exp_q.push_back({2'b00, 8'h10 + 8'(i)});
    end
    chk("ovf count", 32'(count), 32'(FIFO_DEPTH));
    chk("ovf flag", 32'(overflow), 32'd1);
    for (int i = 0; i < FIFO_DEPTH; i++) pop_check("ovf drain");
    chk("ovf drained", 32'(count), 32'd0);
    rd_en = 1'b1;
    wait_cyc(1);
    rd_en = 1'b0;
    wait_cyc(1);
    chk("empty pop count", 32'(count), 32'd0);
    chk("ovf sticky", 32'(overflow), 32'd1);

    // reset in the middle of a frame
    send_frame(8'h77, 1'b0, 5);
    rst = 1'b1;
    wait_cyc(3);
    rst = 1'b0;
    wait_cyc(3);
    chk("midrst count", 32'(count), 32'd0);
    chk("midrst ovf", 32'(overflow), 32'd0);
    send_ok(8'h33);
    exp_q.push_back({2'b00, 8'h33});
    pop_check("after midrst");

    // typematic repeats
    send_ok(8'h1C);
    send_ok(8'h1C);
    send_ok(8'h1C);
    send_ok(8'hF0);
    send_ok(8'h1C);
    send_ok(8'h1C);
`ifdef PS2_TYPEMATIC_FILTER_EN
    exp_q.push_back({2'b00, 8'h1C});
    exp_q.push_back({2'b01, 8'h1C});
    exp_q.push_back({2'b00, 8'h1C});
`else
    exp_q.push_back({2'b00, 8'h1C});
    exp_q.push_back({2'b00, 8'h1C});
    exp_q.push_back({2'b00, 8'h1C});
    exp_q.push_back({2'b01, 8'h1C});
    exp_q.push_back({2'b00, 8'h1C});
`endif
    chk("typematic count", 32'(count), 32'(exp_q.size()));
    while (exp_q.size() != 0) pop_check("typematic");

    // short glitches on the clock line must not be sampled
    err_base = err_cnt;
    for (int g = 1; g < FILT_LEN; g++) begin
      clk_pc2 = 1'b0;
      wait_cyc(g);
      clk_pc2 = 1'b1;
      wait_cyc(HALF);
    end
    chk("glitch err", 32'(err_cnt - err_base), 32'd0);
    chk("glitch count", 32'(count), 32'd0);
    send_ok(8'h4B);
    exp_q.push_back({2'b00, 8'h4B});
    pop_check("after glitch");

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule

// File: doc/ps2_scan_rx.md
PS2_SCAN_RX -- requirements
Module: ps2_scan_rx

Interface
REQ-001 SHALL have parameter FILT_LEN, default 4, meaning consecutive equal samples (clk cycles) needed to accept a PS/2 line change.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, meaning decoded-event buffer depth; must be a power of 2 and at least 2.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 100000, meaning idle clk cycles inside a frame before the frame is aborted.
REQ-004 SHALL have port clk, input, 1, meaning system clock; the only clock.
REQ-005 SHALL have port rst, input, 1, meaning reset; asynchronous, active-high.
REQ-006 SHALL have port clk_pc2, input, 1, meaning raw PS/2 clock, asynchronous to clk.
REQ-007 SHALL have port data_pc2, input, 1, meaning raw PS/2 data, asynchronous to clk.
REQ-008 SHALL have port rd_en, input, 1, meaning pop the head entry; ignored when out_valid=0.
REQ-009 SHALL have port out_valid, output, 1, meaning the FIFO is non-empty.
REQ-010 SHALL have port out_code, output, 8, meaning head entry scan code (show-ahead).
REQ-011 SHALL have port out_break, output, 1, meaning head entry is a key release (F0 prefix seen).
REQ-012 SHALL have port out_ext, output, 1, meaning head entry is an extended key (E0 prefix seen).
REQ-013 SHALL have port count, output, $clog2(FIFO_DEPTH)+1, meaning number of stored entries.
REQ-014 SHALL have port overflow, output, 1, meaning sticky flag: an event was dropped because the FIFO was full.
REQ-015 SHALL have port frame_err, output, 1, meaning one-cycle pulse on a bad start, parity, stop or timeout.

Function
REQ-016 SHALL pass both PS/2 lines through a 2-flop synchronizer, then a filter whose output changes only after FILT_LEN consecutive equal samples.
REQ-017 SHALL sample filtered data on the cycle after a filtered-clock falling edge is detected.
REQ-018 Frame FSM SHALL have states IDLE, DATA, PARITY and STOP; 11-bit frame; data received LSB first.
REQ-019 In IDLE, start bit 0 SHALL go to DATA; start bit 1 SHALL stay in IDLE and pulse frame_err.
REQ-020 In DATA, the FSM SHALL go to PARITY after 8 bits.
REQ-021 In PARITY, the parity bit SHALL be captured; the FSM then goes to STOP.
REQ-022 In STOP, the frame SHALL be valid only if stop=1 and odd parity holds over 8 data bits plus parity; otherwise pulse frame_err; the FSM returns to IDLE either way.
REQ-023 In any state other than IDLE, TIMEOUT_CYC cycles with no falling edge SHALL return the FSM to IDLE, discard the partial byte and pulse frame_err.
REQ-024 A valid byte 8'hE0 SHALL set ext_pend, and a valid byte 8'hF0 SHALL set brk_pend; neither is pushed.
REQ-025 Any other valid byte SHALL be pushed as {ext_pend, brk_pend, code} one cycle after STOP, then both pending flags clear.
REQ-026 frame_err SHALL clear ext_pend and brk_pend.
REQ-027 Push when full SHALL drop the entry and set overflow; overflow clears only on reset.
REQ-028 Push and pop in the same cycle SHALL both take effect, even when full, with count unchanged.
REQ-029 Pop when empty SHALL do nothing.
REQ-030 Pointers SHALL wrap modulo FIFO_DEPTH.
REQ-031 out_code, out_break and out_ext SHALL be 0 when out_valid=0.

Reset
REQ-032 rst SHALL force the FSM to IDLE and clear the bit counter, timeout counter, pending flags, pointers, count, overflow and frame_err.
REQ-033 rst SHALL preload the filter outputs to 1 (idle PS/2 bus).
REQ-034 Assertion during a frame SHALL abort the frame with no push; the first frame after release is received normally.

Configuration
REQ-035 When macro PS2_TYPEMATIC_FILTER_EN is defined, a make entry equal to the last pushed make {ext,code} with no break in between SHALL be dropped; any break entry clears the remembered make; reset clears it.
REQ-036 When PS2_TYPEMATIC_FILTER_EN is undefined, every decoded entry SHALL be pushed, and no memory register exists.

Structure
REQ-037 Package ps2_pkg SHALL hold the frame state enum, PS2_EXT=8'hE0, PS2_BRK=8'hF0, and the 10-bit entry typedef {ext,brk,code}.
REQ-038 A sub-module ps2_sync_filter SHALL implement the per-line synchronizer and filter, instantiated twice.

Verification
REQ-039 Frame 0x1C with good parity -> out_valid=1, out_code=8'h1C, break=0, ext=0, count=1; rd_en -> out_valid=0.
REQ-040 Frames E0, F0, 75 -> one entry: out_code=8'h75, ext=1, break=1.
REQ-041 Frame 0x1C with a flipped parity bit -> frame_err pulse, no entry; a following F0 1C -> break=1, ext=0.
REQ-042 Send 8 bits then stop toggling for TIMEOUT_CYC+10 cycles -> frame_err pulse, FSM in IDLE; the next frame is received correctly.
REQ-043 FIFO_DEPTH+1 frames with no reads -> count=FIFO_DEPTH, overflow=1, first FIFO_DEPTH codes read back in order.
REQ-044 With PS2_TYPEMATIC_FILTER_EN defined, frames 1C 1C 1C F0 1C 1C -> entries 1C make, 1C break, 1C make; 1-cycle glitches shorter than FILT_LEN on clk_pc2 -> no bit sampled.
